// File: rtl/ps2_key_decoder.sv
//============================================================================
// Module      : ps2_key_decoder
// Description : Turns completed PS/2 scancode bytes into held levels and
//               single-cycle press pulses for six Tetris control keys.
//               It tracks E0/F0 prefixes with a small FSM, abandons a stalled
//               prefix after a timeout, and suppresses keyboard typematic
//               repeats.
//               Optional macro PS2_KEY_DECODER_REPEAT_EN adds DAS/ARR
//               auto-repeat on LEFT, RIGHT and DOWN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 2_000_000
`ifdef PS2_KEY_DECODER_REPEAT_EN
  ,
  parameter int DAS_CYCLES     = 17_000_000,
  parameter int ARR_CYCLES     = 5_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_valid_i,
  input  logic [7:0] scan_byte_i,
  output logic [5:0] key_held_o,
  output logic [5:0] key_press_o,
  output logic       seq_error_o
);

  localparam logic [7:0] c_PFX_EXT = 8'hE0;
  localparam logic [7:0] c_PFX_BRK = 8'hF0;
  localparam int         c_TMO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t             state_q;
  logic [c_TMO_W-1:0] tmo_q;
  logic [5:0]         key_held_q;
  logic [5:0]         key_press_q;
  logic               seq_error_q;

  logic               w_is_pfx;
  logic               w_ext;
  logic [5:0]         w_code_m;
  logic [5:0]         w_make_m;
  logic [5:0]         w_brk_m;
  logic [2:0]         w_rpt_fire;

  // One-hot key for a scancode; extended and plain codes live in disjoint sets.
  function automatic logic [5:0] key_map(input logic ext, input logic [7:0] code);
    logic [5:0] m;
    m = 6'b000000;
    if (ext) begin
      case (code)
        8'h6B:   m = 6'b000001;
        8'h74:   m = 6'b000010;
        8'h72:   m = 6'b000100;
        8'h75:   m = 6'b001000;
        default: m = 6'b000000;
      endcase
    end else begin
      case (code)
        8'h29:   m = 6'b010000;
        8'h12:   m = 6'b100000;
        default: m = 6'b000000;
      endcase
    end
    return m;
  endfunction

  assign w_is_pfx = (scan_byte_i == c_PFX_EXT) || (scan_byte_i == c_PFX_BRK);
  assign w_ext    = (state_q == S_EXT) || (state_q == S_EXT_BRK);
  assign w_code_m = key_map(w_ext, scan_byte_i);

  // A final (non-prefix) byte is a make from IDLE/EXT and a break from BRK/EXT_BRK.
  assign w_make_m = (scan_valid_i && !w_is_pfx &&
                     (state_q == S_IDLE || state_q == S_EXT)) ? w_code_m : 6'b000000;
  assign w_brk_m  = (scan_valid_i && !w_is_pfx &&
                     (state_q == S_BRK || state_q == S_EXT_BRK)) ? w_code_m : 6'b000000;

  // Prefix FSM, prefix timeout and registered key outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      key_held_q  <= '0;
      key_press_q <= '0;
      seq_error_q <= 1'b0;
    end else begin
      seq_error_q <= 1'b0;
      key_held_q  <= (key_held_q | w_make_m) & ~w_brk_m;
      key_press_q <= (w_make_m & ~key_held_q) | {3'b000, w_rpt_fire};
      if (scan_valid_i) begin
        // A byte always wins over a coincident timeout expiry.
        tmo_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (scan_byte_i == c_PFX_EXT)      state_q <= S_EXT;
            else if (scan_byte_i == c_PFX_BRK) state_q <= S_BRK;
            else                               state_q <= S_IDLE;
          end
          S_EXT: begin
            if (scan_byte_i == c_PFX_BRK)      state_q <= S_EXT_BRK;
            else if (scan_byte_i == c_PFX_EXT) state_q <= S_EXT;
            else                               state_q <= S_IDLE;
          end
          default: begin
            // BRK / EXT_BRK: any further prefix is an illegal order.
            state_q     <= S_IDLE;
            seq_error_q <= w_is_pfx;
          end
        endcase
      end else if (state_q != S_IDLE) begin
        if (tmo_q == c_TMO_LAST) begin
          state_q     <= S_IDLE;
          tmo_q       <= '0;
          seq_error_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

`ifdef PS2_KEY_DECODER_REPEAT_EN
  localparam int c_RPT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

  logic [c_RPT_W-1:0] rpt_cnt_q [3];

  // A counter at 1 fires this cycle unless the same cycle breaks the key.
  always_comb begin
    w_rpt_fire = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_rpt_fire[i] = (rpt_cnt_q[i] == c_RPT_W'(1)) && !w_brk_m[i];
    end
  end

  // DAS/ARR down-counters for the movement keys; zero means idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) rpt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_brk_m[i])                           rpt_cnt_q[i] <= '0;
        else if (w_make_m[i] && !key_held_q[i])   rpt_cnt_q[i] <= c_RPT_W'(DAS_CYCLES);
        else if (rpt_cnt_q[i] == c_RPT_W'(1))     rpt_cnt_q[i] <= c_RPT_W'(ARR_CYCLES);
        else if (rpt_cnt_q[i] != '0)              rpt_cnt_q[i] <= rpt_cnt_q[i] - 1'b1;
      end
    end
  end
`else
  assign w_rpt_fire = 3'b000;
`endif

  assign key_held_o  = key_held_q;
  assign key_press_o = key_press_q;
  assign seq_error_o = seq_error_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
//============================================================================
// Module      : tb_ps2_key_decoder
// Description : Directed self-checking bench for ps2_key_decoder.
//               Optional macro PS2_KEY_DECODER_REPEAT_EN adds the
//               auto-repeat scenario.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ps2_key_decoder;

  localparam int c_TMO = 40;
  localparam int c_DAS = 100;
  localparam int c_ARR = 20;

  logic       clk;
  logic       rst_n;
  logic       scan_valid;
  logic [7:0] scan_byte;
  logic [5:0] key_held;
  logic [5:0] key_press;
  logic       seq_error;

  int n_tests;
  int n_fail;
  int press_cnt [6];
  int err_cnt;
  int cyc;
  int rpt_cyc [$];

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(c_TMO)
`ifdef PS2_KEY_DECODER_REPEAT_EN
    ,
    .DAS_CYCLES(c_DAS),
    .ARR_CYCLES(c_ARR)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_valid_i (scan_valid),
    .scan_byte_i  (scan_byte),
    .key_held_o   (key_held),
    .key_press_o  (key_press),
    .seq_error_o  (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: outputs are sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      for (int i = 0; i < 6; i++) press_cnt[i] <= press_cnt[i] + int'(key_press[i]);
      err_cnt <= err_cnt + int'(seq_error);
      if (key_press[1]) rpt_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one byte for one clock; returns just after the falling edge that sees the result.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_byte  = b;
    @(negedge clk);
    scan_valid = 1'b0;
    scan_byte  = 8'h00;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int p4_before;
  int p0_before;
  int err_before;
  int total_before;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    err_cnt    = 0;
    cyc        = 0;
    for (int i = 0; i < 6; i++) press_cnt[i] = 0;
    scan_valid = 1'b0;
    scan_byte  = 8'h00;
    rst_n      = 1'b0;
    idle(3);
    check_eq("rst_held",  32'(key_held),  32'h0);
    check_eq("rst_press", 32'(key_press), 32'h0);
    check_eq("rst_err",   32'(seq_error), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // DROP make, then typematic repeat.
    send_byte(8'h29);
    check_eq("drop_held",       32'(key_held),  32'h10);
    check_eq("drop_press_now",  32'(key_press), 32'h10);
    idle(1);
    check_eq("drop_press_gone", 32'(key_press), 32'h0);
    send_byte(8'h29);
    idle(1);
    check_eq("drop_rep_cnt",  32'(press_cnt[4]), 32'd1);
    check_eq("drop_rep_held", 32'(key_held),     32'h10);

    // LEFT extended make then extended break.
    send_byte(8'hE0);
    send_byte(8'h6B);
    check_eq("left_held", 32'(key_held), 32'h11);
    idle(1);
    check_eq("left_cnt",  32'(press_cnt[0]), 32'd1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    check_eq("left_brk",   32'(key_held), 32'h10);
    check_eq("left_noerr", 32'(err_cnt),  32'd0);
    send_byte(8'hF0);
    send_byte(8'h29);
    check_eq("drop_brk", 32'(key_held), 32'h0);

    // HOLD and ROTATE together, release HOLD only.
    send_byte(8'h12);
    send_byte(8'hE0);
    send_byte(8'h75);
    check_eq("multi_held", 32'(key_held), 32'h28);
    send_byte(8'hF0);
    send_byte(8'h12);
    check_eq("multi_brk",  32'(key_held), 32'h08);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_eq("rot_brk",    32'(key_held), 32'h0);

    // Stalled E0 prefix times out once; a following plain 6B is unmapped.
    send_byte(8'hE0);
    idle(c_TMO + 5);
    check_eq("tmo_err", 32'(err_cnt), 32'd1);
    p0_before = press_cnt[0];
    send_byte(8'h6B);
    idle(1);
    check_eq("tmo_6b_held",  32'(key_held),     32'h0);
    check_eq("tmo_6b_press", 32'(press_cnt[0]), 32'(p0_before));

    // Unmapped codes change nothing; F0 E0 is an illegal order.
    total_before = 0;
    for (int i = 0; i < 6; i++) total_before += press_cnt[i];
    send_byte(8'h1C);
    send_byte(8'hFA);
    send_byte(8'hE0);
    send_byte(8'h29);
    idle(1);
    begin
      int total_now;
      total_now = 0;
      for (int i = 0; i < 6; i++) total_now += press_cnt[i];
      check_eq("unmap_press", 32'(total_now), 32'(total_before));
    end
    check_eq("unmap_held", 32'(key_held), 32'h0);
    check_eq("unmap_err",  32'(err_cnt),  32'd1);
    send_byte(8'hF0);
    send_byte(8'hE0);
    check_eq("illegal_pulse", 32'(seq_error), 32'h1);
    idle(1);
    check_eq("illegal_err", 32'(err_cnt), 32'd2);
    send_byte(8'h29);
    check_eq("illegal_idle", 32'(key_held), 32'h10);
    send_byte(8'hF0);
    send_byte(8'h29);

    // Byte landing on the exact expiry cycle is processed, timeout dropped.
    err_before = err_cnt;
    send_byte(8'hE0);
    idle(c_TMO - 2);
    send_byte(8'h6B);
    idle(1);
    check_eq("edge_held", 32'(key_held), 32'h01);
    check_eq("edge_err",  32'(err_cnt),  32'(err_before));
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);

    // One cycle later the prefix has already expired.
    send_byte(8'hE0);
    idle(c_TMO - 1);
    send_byte(8'h6B);
    idle(1);
    check_eq("late_held", 32'(key_held), 32'h0);
    check_eq("late_err",  32'(err_cnt),  32'(err_before + 1));

    // Reset mid-sequence drops held keys; FSM restarts in IDLE.
    send_byte(8'h29);
    send_byte(8'hF0);
    rst_n = 1'b0;
    idle(2);
    check_eq("midrst_held", 32'(key_held), 32'h0);
    rst_n = 1'b1;
    idle(1);
    p4_before = press_cnt[4];
    send_byte(8'h29);
    idle(1);
    check_eq("midrst_make", 32'(press_cnt[4]), 32'(p4_before + 1));
    send_byte(8'hF0);
    send_byte(8'h29);

`ifdef PS2_KEY_DECODER_REPEAT_EN
    // RIGHT held ~195 cycles: pulses at make, +100, +120, +140, +160, +180.
    rpt_cyc.delete();
    send_byte(8'hE0);
    send_byte(8'h74);
    idle(188);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    idle(60);
    check_eq("rpt_count", 32'(rpt_cyc.size()), 32'd6);
    if (rpt_cyc.size() >= 3) begin
      check_eq("rpt_das", 32'(rpt_cyc[1] - rpt_cyc[0]), 32'(c_DAS));
      check_eq("rpt_arr", 32'(rpt_cyc[2] - rpt_cyc[1]), 32'(c_ARR));
    end
    // ROTATE never auto-repeats.
    p0_before = press_cnt[3];
    send_byte(8'hE0);
    send_byte(8'h75);
    idle(150);
    check_eq("rot_norpt", 32'(press_cnt[3]), 32'(p0_before + 1));
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
